// File: rtl/brick_field.sv
// Brick-breaker playfield: brick map, paddle position, score and game state.
// The ball itself is tracked elsewhere. This block only observes the ball each
// tick, knocks out the bricks the ball touches, and decides win/loss.
module brick_field #(
    parameter int PADDLE_W    = 4,
    parameter int PADDLE_INIT = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         start,
    input  logic         move_left,
    input  logic         move_right,
    input  logic [3:0]   Ball_rowIndex,
    input  logic [3:0]   Ball_colIndex,
    input  logic [1:0]   Ball_direction,
    output logic [191:0] data,
    output logic [3:0]   paddle_col,
    output logic [5:0]   bricks_left,
    output logic [7:0]   score,
    output logic [1:0]   game_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    // Reload image: rows 1..3 fully populated, every other row empty.
    localparam logic [175:0] BRICK_INIT  = {112'd0, {48{1'b1}}, 16'd0};
    localparam logic [5:0]   BRICK_COUNT = 6'd48;
    localparam logic [3:0]   PADDLE_RST  = 4'(PADDLE_INIT);
    localparam logic [3:0]   PADDLE_MAX  = 4'(16 - PADDLE_W);
    localparam logic [4:0]   PADDLE_W5   = 5'(PADDLE_W);

    genvar gi;

    state_t         state_reg;
    logic [175:0]   bricks_reg;
    logic [3:0]     paddle_reg;
    logic [5:0]     left_reg;
    logic [7:0]     score_reg;

    // True when column c (5-bit, so off-grid values never match) is under the paddle at p.
    function automatic logic covers(input logic [4:0] c, input logic [3:0] p);
        return (c >= {1'b0, p}) && (c < ({1'b0, p} + PADDLE_W5));
    endfunction

    // Neighbour coordinates are computed 5 bits wide so a step off either
    // edge (including 0-1 wrapping) lands outside the legal range.
    logic [4:0] row_n;
    logic [4:0] col_n;
    logic       row_b_ok;
    logic       row_n_ok;
    logic       col_n_ok;
    logic [7:0] v_idx;
    logic [7:0] h_idx;
    logic [7:0] d_idx;

    assign row_n    = Ball_direction[1] ? ({1'b0, Ball_rowIndex} + 5'd1)
                                        : ({1'b0, Ball_rowIndex} - 5'd1);
    assign col_n    = Ball_direction[0] ? ({1'b0, Ball_colIndex} + 5'd1)
                                        : ({1'b0, Ball_colIndex} - 5'd1);
    // Row 11 is the paddle row and rows above 11 do not exist: neither is brick space.
    assign row_b_ok = (Ball_rowIndex < 4'd11);
    assign row_n_ok = (row_n < 5'd11);
    assign col_n_ok = ~col_n[4];
    assign v_idx    = {row_n[3:0], Ball_colIndex};
    assign h_idx    = {Ball_rowIndex, col_n[3:0]};
    assign d_idx    = {row_n[3:0], col_n[3:0]};

    // One-hot selects of the three candidate cells, empty when the cell is not brick space.
    logic [175:0] v_sel;
    logic [175:0] h_sel;
    logic [175:0] d_sel;

    generate
        for (gi = 0; gi < 176; gi++) begin : g_cell
            assign v_sel[gi] = row_n_ok && (v_idx == 8'(gi));
            assign h_sel[gi] = row_b_ok && col_n_ok && (h_idx == 8'(gi));
            assign d_sel[gi] = row_n_ok && col_n_ok && (d_idx == 8'(gi));
        end
    endgenerate

    // The diagonal is only hit when the ball slips between two empty side cells.
    logic         v_set;
    logic         h_set;
    logic         d_clr;
    logic [175:0] clear_mask;
    logic [1:0]   clear_cnt;
    logic [5:0]   left_next;
    logic [8:0]   score_sum;
    logic [7:0]   score_next;

    assign v_set      = |(v_sel & bricks_reg);
    assign h_set      = |(h_sel & bricks_reg);
    assign d_clr      = (|(d_sel & bricks_reg)) & ~v_set & ~h_set;
    assign clear_mask = ({176{v_set}} & v_sel) | ({176{h_set}} & h_sel) | ({176{d_clr}} & d_sel);
    assign clear_cnt  = {1'b0, v_set} + {1'b0, h_set} + {1'b0, d_clr};
    assign left_next  = left_reg - {4'd0, clear_cnt};
    assign score_sum  = {1'b0, score_reg} + {7'd0, clear_cnt};
    assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

    // Loss: ball in the last brick row heading down with no paddle cell below
    // its column or the column it is drifting into. Uses the pre-move paddle.
    logic ball_covered;
    logic next_covered;
    logic loss_hit;

    assign ball_covered = covers({1'b0, Ball_colIndex}, paddle_reg);
    assign next_covered = col_n_ok && covers(col_n, paddle_reg);
    assign loss_hit     = (Ball_rowIndex == 4'd10) && Ball_direction[1]
                          && !ball_covered && !next_covered;

    // Paddle step for this tick; left raises the column index, right lowers it.
    logic [3:0] paddle_next;

    always_comb begin
        paddle_next = paddle_reg;
        if (move_left && !move_right && (paddle_reg < PADDLE_MAX)) begin
            paddle_next = paddle_reg + 4'd1;
        end else if (move_right && !move_left && (paddle_reg != 4'd0)) begin
            paddle_next = paddle_reg - 4'd1;
        end
    end

    // Game state machine together with all playfield state it owns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            bricks_reg <= BRICK_INIT;
            paddle_reg <= PADDLE_RST;
            left_reg   <= BRICK_COUNT;
            score_reg  <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        bricks_reg <= bricks_reg & ~clear_mask;
                        left_reg   <= left_next;
                        score_reg  <= score_next;
                        paddle_reg <= paddle_next;
                        if (left_next == 6'd0) begin
                            state_reg <= ST_WON;
                        end else if (loss_hit) begin
                            state_reg <= ST_LOST;
                        end
                    end
                end
                default: begin
                    // WON / LOST: everything frozen until a start reloads the field.
                    if (start) begin
                        state_reg  <= ST_IDLE;
                        bricks_reg <= BRICK_INIT;
                        paddle_reg <= PADDLE_RST;
                        left_reg   <= BRICK_COUNT;
                        score_reg  <= 8'd0;
                    end
                end
            endcase
        end
    end

    // Display map: bricks in rows 0..10, paddle footprint in row 11.
    assign data[175:0] = bricks_reg;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_paddle
            assign data[176 + gi] = covers(5'(gi), paddle_reg);
        end
    endgenerate

    assign paddle_col  = paddle_reg;
    assign bricks_left = left_reg;
    assign score       = score_reg;
    assign game_state  = state_reg;

endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 SHALL have parameter PADDLE_W, default 4, paddle width in cells (legal 1..8).
REQ-002 SHALL have parameter PADDLE_INIT, default 6, paddle_col value after reset and reload.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick  input  1  one-cycle game-step pulse, aligned with the ball-position update.
REQ-006 SHALL have port start  input  1  one-cycle pulse: begin play, or reload after a win or loss.
REQ-007 SHALL have port move_left / move_right  input  1 each  paddle button levels.
REQ-008 SHALL have ports Ball_rowIndex, Ball_colIndex  input  4 each, and Ball_direction  input  2  current ball state.
REQ-009 SHALL have port data  output  192  occupancy map; bit row*16+col, rows 0..11, cols 0..15.
REQ-010 SHALL have ports paddle_col  output  4, bricks_left  output  6, score  output  8, game_state  output  2.

Function
REQ-011 SHALL encode Ball_direction as: 00 = row-1 col-1; 01 = row-1 col+1; 10 = row+1 col-1; 11 = row+1 col+1.
REQ-012 SHALL hold a 176-bit brick register (rows 0..10) that reloads to rows 1..3 all set (48 bricks) and all other rows clear.
REQ-013 SHALL drive data = brick register in bits 0..175, and a paddle mask in row 11 (bits 176+paddle_col .. 176+paddle_col+PADDLE_W-1); combinational from registers.
REQ-014 SHALL implement game_state: IDLE=00, PLAY=01, WON=10, LOST=11.
REQ-015 SHALL move IDLE->PLAY on start; in IDLE, tick is ignored.
REQ-016 SHALL, on start in WON or LOST, reload bricks, paddle_col, bricks_left=48 and score=0, and enter IDLE; score SHALL be held in WON/LOST until that start.
REQ-017 SHALL ignore start while in PLAY.
REQ-018 SHALL act on tick only in PLAY; all effects SHALL be visible the cycle after the tick.
REQ-019 SHALL, on tick, evaluate the vertical neighbour V (row+dr, col), horizontal neighbour H (row, col+dc) and diagonal D (row+dr, col+dc) of the ball, where dr/dc come from REQ-011.
REQ-020 SHALL clear the V and H cells if they are set bricks, and SHALL clear D only when neither V nor H is a set brick.
REQ-021 SHALL skip any cell that is off-grid (row or col outside range, including 4-bit wrap) or in row 11; the paddle is never cleared.
REQ-022 SHALL subtract the number cleared (0..2) from bricks_left, and SHALL add it to score with saturation at 255.
REQ-023 SHALL enter WON on the cycle bricks_left becomes 0; WON SHALL take priority over LOST in the same tick.
REQ-024 SHALL enter LOST on tick when Ball_rowIndex=10, Ball_direction[1]=1, and neither column Ball_colIndex nor Ball_colIndex+dc (if on-grid) lies under the paddle.
REQ-025 SHALL, on tick in PLAY, increment paddle_col when only move_left is high (capped at 16-PADDLE_W), decrement it when only move_right is high (floor 0), and leave it unchanged when both or neither are high.
REQ-026 SHALL evaluate brick clearing and the loss check against paddle_col before the same tick's paddle move.
REQ-027 SHALL freeze the brick register and paddle_col in IDLE, WON and LOST.

Reset
REQ-028 SHALL, while reset=0, asynchronously force game_state=IDLE, paddle_col=PADDLE_INIT, bricks_left=48, score=0 and the brick register to its reload image.
REQ-029 SHALL give reset priority over start and tick; reset mid-PLAY discards all progress.
REQ-030 SHALL resume normal operation on the first rising edge after reset returns high.

Verification
REQ-031 SHALL verify: release reset -> data bits 16..63 set, bits 182..185 set, all other bits 0, game_state=00, bricks_left=48.
REQ-032 SHALL verify: start, then tick with ball (4,5), dir 01 -> bit 53 cleared, bricks_left=47, score=1.
REQ-033 SHALL verify: ball (4,5), dir 00, bits 53 and 68 set -> both cleared and bit 52 untouched; ball (4,5), dir 00, V and H empty -> D bit 52 cleared.
REQ-034 SHALL verify: ball (10,0), dir 10, paddle_col=6 -> no brick change and game_state=LOST; a following start -> IDLE with full reload.
REQ-035 SHALL verify: paddle_col=12 with move_left held for 3 ticks -> stays 12; both buttons held -> unchanged; 7 ticks of move_right -> 5.
REQ-036 SHALL verify: 1 brick left and the clearing tick -> WON, score held; reset asserted mid-PLAY with score=20 -> score=0 and IDLE immediately, without waiting for a clock edge.
